// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out word serializer with one-word holding buffer
// Optional even-parity trailer bit: define PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             CP,
    input  logic             CR,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load,
    output logic             Ready,
    output logic             Sout,
    output logic             SoutVld,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 2);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             data_last;
    logic             last_bit;
    logic             load_direct;
    logic             load_hold;
    logic             head_bit;
`ifdef PISO_PARITY_EN
    logic             par;
`endif

    assign accept    = Load & ~hold_full;
    assign data_last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
`ifdef PISO_PARITY_EN
    assign last_bit  = (state == PARITY);
`else
    assign last_bit  = data_last;
`endif
    // Direct load only when the shifter is free or finishing; hold is empty then.
    assign load_direct = accept && ((state == IDLE) || last_bit);
    assign load_hold   = last_bit && hold_full;
    assign head_bit    = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge CP) begin
        if (CR) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (data_last) begin
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = (hold_full || accept) ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_nxt = (hold_full || accept) ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state != IDLE);
        SoutVld = (state != IDLE);
        Done    = last_bit;
        Sout    = 1'b0;
        if (state == SHIFT) begin
            Sout = head_bit;
        end
`ifdef PISO_PARITY_EN
        else if (state == PARITY) begin
            Sout = par;
        end
`endif
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
`ifdef PISO_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            if (load_direct) begin
                shreg <= Din;
                cnt   <= '0;
`ifdef PISO_PARITY_EN
                par   <= ^Din;
`endif
            end else if (load_hold) begin
                shreg     <= hold;
                hold      <= '0;
                hold_full <= 1'b0;
                cnt       <= '0;
`ifdef PISO_PARITY_EN
                par       <= ^hold;
`endif
            end else if (state == SHIFT) begin
                shreg <= (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                cnt   <= cnt + CW'(1);
            end
            // A word arriving mid-frame waits in the holding register.
            if (accept && (state != IDLE) && !last_bit) begin
                hold      <= Din;
                hold_full <= 1'b1;
            end
        end
    end

    assign Ready = ~hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       CP;
    logic       CR;
    logic [7:0] Din;
    logic       Load;
    logic       ready_m, sout_m, vld_m, busy_m, done_m;
    logic       ready_l, sout_l, vld_l, busy_l, done_l;

    int          checks;
    int          failures;
    int          cyc;
    int          vcnt;
    int          dcnt;
    int          hits;
    logic [63:0] stream;
    logic [63:0] stream2;
    logic [63:0] dmask;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .CP(CP), .CR(CR), .Din(Din), .Load(Load), .Ready(ready_m),
        .Sout(sout_m), .SoutVld(vld_m), .Busy(busy_m), .Done(done_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .CP(CP), .CR(CR), .Din(Din), .Load(Load), .Ready(ready_l),
        .Sout(sout_l), .SoutVld(vld_l), .Busy(busy_l), .Done(done_l)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected frame as it appears in the sample stream (oldest bit highest).
    function automatic logic [63:0] frm(input logic [7:0] w, input bit msb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = msb ? w[i] : w[7-i];
`ifdef PISO_PARITY_EN
        return {55'd0, r, ^w};
`else
        return {56'd0, r};
`endif
    endfunction

    task automatic clr();
        cyc = 0; vcnt = 0; dcnt = 0;
        stream = '0; stream2 = '0; dmask = '0;
    endtask

    task automatic tick();
        @(negedge CP);
        cyc++;
        stream  = {stream[62:0], sout_m};
        stream2 = {stream2[62:0], sout_l};
        if (vld_m) vcnt++;
        if (done_m) begin
            dcnt++;
            if (cyc < 64) dmask[cyc] = 1'b1;
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        Din = 8'h00; Load = 1'b0; CR = 1'b1;
        clr();
        tick();
        check("rst_sout", {63'd0, sout_m}, 64'd0);
        check("rst_vld", {63'd0, vld_m}, 64'd0);
        check("rst_busy", {63'd0, busy_m}, 64'd0);
        check("rst_done", {63'd0, done_m}, 64'd0);
        check("rst_ready", {63'd0, ready_m}, 64'd1);
        CR = 1'b0;

        // Single frame A5
        Din = 8'hA5; Load = 1'b1; clr();
        tick();
        Load = 1'b0;
        repeat (FL - 1) tick();
        check("a5_bits", stream, frm(8'hA5, 1'b1));
        check("a5_vld", 64'(vcnt), 64'(FL));
        check("a5_done_cnt", 64'(dcnt), 64'd1);
        check("a5_done_pos", dmask, 64'd1 << FL);
        tick();
        check("idle_sout", {63'd0, sout_m}, 64'd0);
        check("idle_vld", {63'd0, vld_m}, 64'd0);
        check("idle_busy", {63'd0, busy_m}, 64'd0);
        check("idle_done", {63'd0, done_m}, 64'd0);

        // 05 then 0A via holding register; FF offered while full must be dropped
        clr();
        Din = 8'h05; Load = 1'b1;
        tick();
        Din = 8'h0A;
        tick();
        check("hold_ready_low", {63'd0, ready_m}, 64'd0);
        Din = 8'hFF;
        repeat (FL - 2) tick();
        Load = 1'b0;
        tick();
        check("hold_ready_back", {63'd0, ready_m}, 64'd1);
        repeat (FL - 1) tick();
        check("b2b_bits", stream, (frm(8'h05, 1'b1) << FL) | frm(8'h0A, 1'b1));
        check("b2b_bits_lsb", stream2, (frm(8'h05, 1'b0) << FL) | frm(8'h0A, 1'b0));
        check("b2b_done_pos", dmask, (64'd1 << FL) | (64'd1 << (2 * FL)));
        check("b2b_vld", 64'(vcnt), 64'(2 * FL));
`ifndef PISO_PARITY_EN
        hits = 0;
        for (int i = 0; i <= 12; i++) if (stream[i+:4] == 4'b0101) hits++;
        check("b2b_detect", 64'(hits), 64'd2);
`endif
        tick();
        check("b2b_idle", {63'd0, busy_m}, 64'd0);

        // Direct load on the last-bit cycle with holding empty
        clr();
        Din = 8'h81; Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (FL - 1) tick();
        Din = 8'hC3; Load = 1'b1;
        tick();
        Load = 1'b0;
        check("direct_ready", {63'd0, ready_m}, 64'd1);
        repeat (FL - 1) tick();
        check("direct_bits", stream, (frm(8'h81, 1'b1) << FL) | frm(8'hC3, 1'b1));
        check("direct_done_pos", dmask, (64'd1 << FL) | (64'd1 << (2 * FL)));
        tick();

        // Bit order: 01 MSB-first vs LSB-first
        clr();
        Din = 8'h01; Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (FL - 1) tick();
        check("order_msb", stream, frm(8'h01, 1'b1));
        check("order_lsb", stream2, frm(8'h01, 1'b0));
        tick();

        // Reset during bit 4 with a word pending
        clr();
        Din = 8'hA5; Load = 1'b1;
        tick();
        Din = 8'h3C;
        tick();
        Load = 1'b0;
        tick();
        tick();
        CR = 1'b1;
        tick();
        check("midrst_sout", {63'd0, sout_m}, 64'd0);
        check("midrst_vld", {63'd0, vld_m}, 64'd0);
        check("midrst_busy", {63'd0, busy_m}, 64'd0);
        check("midrst_ready", {63'd0, ready_m}, 64'd1);
        check("midrst_bits", stream, 64'h14);
        CR = 1'b0;
        clr();
        repeat (20) tick();
        check("midrst_silent", 64'(vcnt), 64'd0);
        check("midrst_no_done", 64'(dcnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits; legal range 2..32.
REQ-002 Parameter: MSB_FIRST, default 1; 1 = shift MSB first, 0 = shift LSB first.
REQ-003 Port: CP  input  1  clock; all state updates on the rising edge.
REQ-004 Port: CR  input  1  reset; synchronous, active-high.
REQ-005 Port: Din  input  WIDTH  parallel word to serialize.
REQ-006 Port: Load  input  1  word valid; Din is accepted at a rising edge where Load=1 and Ready=1.
REQ-007 Port: Ready  output  1  high when a word can be accepted (holding buffer empty).
REQ-008 Port: Sout  output  1  serial bit stream; feeds the downstream sequence detector's serial input.
REQ-009 Port: SoutVld  output  1  high while Sout carries a frame bit.
REQ-010 Port: Busy  output  1  high while the shifter holds a frame.
REQ-011 Port: Done  output  1  one-cycle pulse coincident with the last bit of each frame.

Function
REQ-012 Structure: one holding register (1 word) plus one shift register, a bit counter of ceil(log2(WIDTH+2)) bits, and a state machine with states IDLE, SHIFT and, when configured, PARITY.
REQ-013 Ready SHALL equal NOT(holding full); registered, no combinational path from Load.
REQ-014 IDLE + accept: the word loads directly into the shifter; its first bit appears on Sout in the cycle after the accepting edge; state goes to SHIFT.
REQ-015 SHIFT + accept: the word goes to the holding register; Ready drops to 0 the next cycle.
REQ-016 Each bit SHALL be held on Sout for exactly one cycle; data bit order follows MSB_FIRST.
REQ-017 Last-bit cycle with holding full: at the next edge the held word transfers to the shifter, Ready returns to 1, and the next frame's first bit follows with no gap.
REQ-018 Last-bit cycle with holding empty and Load=1: the word loads directly into the shifter with no gap.
REQ-019 Last-bit cycle with holding empty and Load=0: next state IDLE.
REQ-020 Load with Ready=0 SHALL be ignored; neither buffered word changes.
REQ-021 In IDLE: Sout=0, SoutVld=0, Busy=0, Done=0.
REQ-022 Done SHALL be 1 only in the final bit cycle of a frame; across back-to-back frames it pulses once per frame.

Reset
REQ-023 CR=1 at a rising edge SHALL force IDLE, clear the shifter, holding register and bit counter, and take precedence over Load.
REQ-024 Outputs after a reset edge: Sout=0, SoutVld=0, Busy=0, Done=0, Ready=1.
REQ-025 Reset mid-frame discards the active and pending words; no partial bits are emitted afterward.

Configuration
REQ-026 Macro PISO_PARITY_EN defined: after the WIDTH data bits, one extra bit SHALL be emitted in state PARITY, equal to the XOR of the word (even parity); SoutVld=1 and Done=1 on that bit; frame length WIDTH+1 cycles.
REQ-027 Macro PISO_PARITY_EN undefined: the PARITY state and parity logic are absent; frame length WIDTH cycles; Done on the last data bit.

Verification
REQ-028 Reset, then Load 8'hA5 (MSB_FIRST=1) -> Sout 1,0,1,0,0,1,0,1 on cycles 1-8 after accept; SoutVld=1 for 8 cycles; Done on cycle 8 only.
REQ-029 Load 8'h05 then 8'h0A, each held until accepted -> 16 contiguous bits 00000101 00001010; the detector downstream flags 0101 twice.
REQ-030 While the holding register is full, Load 8'hFF with Ready=0 -> 8'hFF never appears on Sout.
REQ-031 CR=1 during bit 4 with a word pending -> next cycle Sout=0, SoutVld=0, Busy=0, Ready=1; no further bits.
REQ-032 PISO_PARITY_EN defined, Load 8'h07 -> 9 bits 0000011 1,1; Done on bit 9 only.
REQ-033 MSB_FIRST=0, Load 8'h01 -> first bit 1, then seven 0s.
